acc_seq_ctrl: RTL and testbench



---
 rtl/acc_seq_pkg.sv | 16 +
 rtl/acc_unit.sv | 38 +++
 rtl/acc_seq_ctrl.sv | 118 +++++++++++
 tb/tb_acc_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_pkg.sv
// Shared definitions for the sample accumulator sequencer: default widths
// and the binary state encoding of the run FSM.
package acc_seq_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int ACC_W_DEF  = 20;
  localparam int CNT_W_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/acc_unit.sv
// ACC_W-bit running accumulator with synchronous clear and enable.
// Exposes the next sum and the carry out of the top bit so the sequencer
// can latch the final sum and track wrap-around on the same edge.
module acc_unit #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [ACC_W-1:0]  sum_next,
  output logic              carry
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum_ext;

  // zero-extended add with one extra bit to capture the carry out
  always_comb begin
    sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, din};
    sum_next = sum_ext[ACC_W-1:0];
    carry    = sum_ext[ACC_W];
  end

  // accumulator register; clear wins over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_next;
    end
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Run sequencer for the sample accumulator: clears, sums a bounded number
// of qualified ADC samples, then holds the sum until acknowledged.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start with a non-zero sample count
//   ST_CLEAR | one cycle: zero accumulator and overflow, load counter
//   ST_ACCUM | add each valid sample, count down to the last one
//   ST_HOLD  | result latched and valid until result_ack
module acc_seq_ctrl
  import acc_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              abort,
  input  logic              result_ack,
  output logic              busy,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  output logic              overflow,
  output logic [CNT_W-1:0]  samples_left
);

  state_t           state;
  logic [CNT_W-1:0] cnt_cap;
  logic             abort_hit;
  logic             acc_clr;
  logic             acc_en;
  logic [ACC_W-1:0] sum_next;
  logic             carry;

  // accumulator control; an abort suppresses any update in the same cycle
  always_comb begin
    abort_hit = abort && (state != ST_IDLE);
    acc_clr   = (state == ST_CLEAR) && !abort_hit;
    acc_en    = (state == ST_ACCUM) && adc_valid && !abort_hit;
  end

  acc_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .en       (acc_en),
    .din      (adc_data),
    .sum_next (sum_next),
    .carry    (carry)
  );

  // run FSM with registered status outputs, count-down and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      cnt_cap      <= '0;
      samples_left <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else if (abort_hit) begin
      // result and overflow deliberately keep their last values
      state        <= ST_IDLE;
      busy         <= 1'b0;
      samples_left <= '0;
      result_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && (num_samples != '0)) begin
            cnt_cap <= num_samples;
            busy    <= 1'b1;
            state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          overflow     <= 1'b0;
          samples_left <= cnt_cap;
          state        <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (adc_valid) begin
            if (carry) begin
              overflow <= 1'b1;
            end
            samples_left <= samples_left - CNT_W'(1);
            if (samples_left == CNT_W'(1)) begin
              result       <= sum_next;
              result_valid <= 1'b1;
              state        <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a run-level model.
module tb_acc_seq_ctrl;

  localparam int DATA_W = 12;
  localparam int ACC_W  = 20;
  localparam int CNT_W  = 10;
  localparam longint MOD = 64'd1 << ACC_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  num_samples;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic              abort;
  logic              result_ack;
  logic              busy;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              overflow;
  logic [CNT_W-1:0]  samples_left;

  acc_seq_ctrl #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .abort        (abort),
    .result_ack   (result_ack),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow),
    .samples_left (samples_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // run-level model: phase 0 idle, 1 clearing, 2 summing, 3 holding
  int     m_phase;
  int     m_cap;
  int     m_left;
  longint m_sum;
  longint m_result;
  bit     m_rv;
  bit     m_ovf;

  task automatic model_reset();
    m_phase = 0; m_cap = 0; m_left = 0; m_sum = 0;
    m_result = 0; m_rv = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit s, input int ns, input bit v, input int d,
                            input bit ab, input bit ak);
    if (ab && m_phase != 0) begin
      m_phase = 0; m_rv = 0; m_left = 0;
    end else begin
      case (m_phase)
        0: if (s && ns != 0) begin m_cap = ns; m_phase = 1; end
        1: begin m_sum = 0; m_ovf = 0; m_left = m_cap; m_phase = 2; end
        2: if (v) begin
             m_sum  = m_sum + d;
             m_ovf  = (m_sum >= MOD);
             m_left = m_left - 1;
             if (m_left == 0) begin
               m_result = m_sum % MOD;
               m_rv     = 1;
               m_phase  = 3;
             end
           end
        default: if (ak) begin m_rv = 0; m_phase = 0; end
      endcase
    end
  endtask

  task automatic check_fld(input string name, input longint act, input longint exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_fld({tag, ".busy"},         longint'(busy),         longint'(m_phase != 0));
    check_fld({tag, ".result_valid"}, longint'(result_valid), longint'(m_rv));
    check_fld({tag, ".result"},       longint'(result),       m_result);
    check_fld({tag, ".overflow"},     longint'(overflow),     longint'(m_ovf));
    check_fld({tag, ".samples_left"}, longint'(samples_left), longint'(m_left));
  endtask

  // one clock of stimulus; the model advances with the same edge
  task automatic apply(input bit s, input int ns, input bit v, input int d,
                       input bit ab, input bit ak);
    @(negedge clk);
    start       = s;
    num_samples = CNT_W'(ns);
    adc_valid   = v;
    adc_data    = DATA_W'(d);
    abort       = ab;
    result_ack  = ak;
    @(posedge clk);
    model_step(s, ns, v, d, ab, ak);
    #1;
    n_vec++;
  endtask

  task automatic idle_in();
    apply(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit s; int ns; bit v; int d; bit ab; bit ak;
    bit e_busy; bit e_rv; int e_res; bit e_ovf; int e_left;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // first run: 4 back-to-back samples 1..4, then a zero-length start
    tbl[0] = '{1, 4, 0, 0, 0, 0,  1, 0,  0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0,  1, 0,  0, 0, 4};
    tbl[2] = '{0, 0, 1, 1, 0, 0,  1, 0,  0, 0, 3};
    tbl[3] = '{0, 0, 1, 2, 0, 0,  1, 0,  0, 0, 2};
    tbl[4] = '{0, 0, 1, 3, 0, 0,  1, 0,  0, 0, 1};
    tbl[5] = '{0, 0, 1, 4, 0, 0,  1, 1, 10, 0, 0};
    tbl[6] = '{0, 0, 1, 9, 0, 0,  1, 1, 10, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 1,  0, 0, 10, 0, 0};
    tbl[8] = '{1, 0, 0, 0, 0, 0,  0, 0, 10, 0, 0};
    tbl[9] = '{0, 0, 0, 0, 0, 0,  0, 0, 10, 0, 0};

    rst_n = 1'b0; start = 0; num_samples = '0; adc_valid = 0; adc_data = '0;
    abort = 0; result_ack = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model("reset");
    n_vec++;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].s, tbl[i].ns, tbl[i].v, tbl[i].d, tbl[i].ab, tbl[i].ak);
      check_fld($sformatf("tbl%0d.busy", i),         busy,         tbl[i].e_busy);
      check_fld($sformatf("tbl%0d.result_valid", i), result_valid, tbl[i].e_rv);
      check_fld($sformatf("tbl%0d.result", i),       result,       tbl[i].e_res);
      check_fld($sformatf("tbl%0d.overflow", i),     overflow,     tbl[i].e_ovf);
      check_fld($sformatf("tbl%0d.samples_left", i), samples_left, tbl[i].e_left);
    end

    // gapped samples 5,7,9 with starts injected mid-run
    apply(1, 3, 0, 0, 0, 0); check_model("gap.start");
    idle_in();               check_model("gap.clear");
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 1, 5 + 2 * k, 0, 0);
      check_model("gap.sample");
      check_fld("gap.left", samples_left, 2 - k);
      if (k < 2) begin
        apply(1, 7, 0, 100, 0, 0); check_model("gap.idle_start");
        apply(0, 0, 0, 200, 0, 0); check_model("gap.idle");
      end
    end
    check_fld("gap.result", result, 21);
    // start together with ack in HOLD must not launch a run
    apply(1, 5, 0, 0, 0, 1); check_model("gap.ack_start");
    idle_in();               check_model("gap.after_ack");
    check_fld("gap.busy_after_ack", busy, 0);

    // long run that wraps the accumulator, then a short clean run
    apply(1, 257, 0, 0, 0, 0);
    idle_in();
    for (int k = 0; k < 257; k++) apply(0, 0, 1, 12'hFFF, 0, 0);
    check_model("ovf.done");
    check_fld("ovf.result", result, 3839);
    check_fld("ovf.flag", overflow, 1);
    apply(0, 0, 0, 0, 0, 1); check_model("ovf.ack");
    check_fld("ovf.sticky_idle", overflow, 1);
    apply(1, 2, 0, 0, 0, 0);
    idle_in();               check_model("ovf.clear2");
    apply(0, 0, 1, 1, 0, 0);
    apply(0, 0, 1, 1, 0, 0); check_model("run2.done");
    check_fld("run2.result", result, 2);
    check_fld("run2.ovf", overflow, 0);
    apply(0, 0, 0, 0, 0, 1);

    // abort after 3 of 8 samples, then a single-sample run
    apply(1, 8, 0, 0, 0, 0);
    idle_in();
    for (int k = 0; k < 3; k++) apply(0, 0, 1, 50, 0, 0);
    apply(0, 0, 1, 50, 1, 0); check_model("abort");
    check_fld("abort.busy", busy, 0);
    check_fld("abort.result_kept", result, 2);
    apply(0, 0, 0, 0, 1, 0); check_model("abort.idle");
    apply(1, 1, 0, 0, 0, 0);
    idle_in();
    apply(0, 0, 1, 6, 0, 0); check_model("one.done");
    check_fld("one.result", result, 6);

    // long hold with repeated starts, then ack
    for (int k = 0; k < 20; k++) begin
      apply(1, 3, 1, 77, 0, 0);
      check_model("hold");
      check_fld("hold.rv", result_valid, 1);
      check_fld("hold.result", result, 6);
    end
    apply(0, 0, 0, 0, 0, 1); check_model("hold.ack");
    check_fld("hold.rv_low", result_valid, 0);

    // asynchronous reset during accumulation
    apply(1, 5, 0, 0, 0, 0);
    idle_in();
    apply(0, 0, 1, 900, 0, 0);
    apply(0, 0, 1, 900, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    n_vec++;
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit s, v, ab, ak;
      int ns, d;
      s  = ($urandom_range(0, 3) == 0);
      ns = ($urandom_range(0, 15) == 0) ? int'($urandom_range(256, 300))
                                        : int'($urandom_range(0, 6));
      v  = ($urandom_range(0, 9) < 6);
      d  = ($urandom_range(0, 1) == 1) ? 12'hFFF : int'($urandom_range(0, 4095));
      ab = !s && ($urandom_range(0, 49) == 0);
      ak = ($urandom_range(0, 3) == 0);
      apply(s, ns, v, d, ab, ak);
      check_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
